// File: rtl/cpu_pkg.sv
// Types and constants shared between the fetch queue and the decode stage.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Extended-width queue pointer: index bits plus a wrap bit in the MSB.
module fq_ptr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling FIFO of (pc, inst) pairs with single-cycle flush.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = cpu_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [XLEN-1:0]          enq_inst,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [XLEN-1:0]          deq_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  fq_entry_t entries [DEPTH];

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          empty;
  logic          full;
  logic          enq_fire;
  logic          deq_fire;

  assign head_idx = head_ptr[AW-1:0];
  assign tail_idx = tail_ptr[AW-1:0];

  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_idx == tail_idx) && (head_ptr[AW] != tail_ptr[AW]);

  assign enq_ready = !full && !flush && !rst;
  assign deq_valid = !empty;

  // enq_ready already excludes flush/rst; the dequeue side must mask them explicitly.
  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready && !flush && !rst;

  assign count = tail_ptr - head_ptr;

  always_comb begin
    deq_pc   = '0;
    deq_inst = NOP_INST;
    if (!empty) begin
      deq_pc   = entries[head_idx].pc;
      deq_inst = entries[head_idx].inst;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      entries[tail_idx] <= '{pc: enq_pc, inst: enq_inst};
    end
  end

  fq_ptr #(.WIDTH(PW)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (deq_fire),
    .ptr (head_ptr)
  );

  fq_ptr #(.WIDTH(PW)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (enq_fire),
    .ptr (tail_ptr)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed checks of inst_fetch_queue against a queue-based model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  enq_valid;
  logic                  enq_ready;
  logic [XLEN-1:0]       enq_pc;
  logic [XLEN-1:0]       enq_inst;
  logic                  deq_valid;
  logic                  deq_ready;
  logic [XLEN-1:0]       deq_pc;
  logic [XLEN-1:0]       deq_inst;
  logic [$clog2(DEPTH):0] count;

  inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_inst  (enq_inst),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_inst  (deq_inst),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t model_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pc_seq = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance model and DUT.
  task automatic cycle(input logic r, input logic f, input logic ev,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic dr, input bit chk = 1'b1);
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    int unsigned exp_count;
    ent_t        e;
    rst = r; flush = f; enq_valid = ev; enq_pc = pc; enq_inst = inst; deq_ready = dr;
    #2;
    exp_count = model_q.size();
    exp_valid = (exp_count != 0);
    exp_pc    = exp_valid ? model_q[0].pc   : 32'h0;
    exp_inst  = exp_valid ? model_q[0].inst : NOP;
    exp_ready = (exp_count < DEPTH) && !f && !r;
    if (chk) begin
      check("count",     64'(count),     64'(exp_count));
      check("deq_valid", 64'(deq_valid), 64'(exp_valid));
      check("deq_pc",    64'(deq_pc),    64'(exp_pc));
      check("deq_inst",  64'(deq_inst),  64'(exp_inst));
      check("enq_ready", 64'(enq_ready), 64'(exp_ready));
    end
    if (r || f) begin
      model_q.delete();
    end else begin
      if (exp_valid && dr) void'(model_q.pop_front());
      if (ev && exp_ready) begin
        e.pc = pc; e.inst = inst;
        model_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic dr);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, dr);
  endtask

  task automatic push(input logic [31:0] pc, input logic dr);
    cycle(1'b0, 1'b0, 1'b1, pc, $urandom, dr);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_pc = '0; enq_inst = '0; deq_ready = 1'b0;

    // Reset: first cycle state is undefined, second is checked.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    idle_cycle(1'b0);
    check("ready_after_reset", 64'(enq_ready), 64'(1));

    // Fill to full, then a fifth enqueue must be refused.
    push(32'h0, 1'b0);
    push(32'h4, 1'b0);
    push(32'h8, 1'b0);
    push(32'hC, 1'b0);
    push(32'h14, 1'b0);
    check("full_count", 64'(count), 64'(4));

    // Full + drain: dequeue-only first, then both fire.
    push(32'h10, 1'b1);
    check("drain_cnt1", 64'(count), 64'(3));
    push(32'h10, 1'b1);
    check("drain_cnt2", 64'(count), 64'(3));
    repeat (4) idle_cycle(1'b1);

    // Wrap-around streaming.
    for (int i = 0; i < 10; i++) begin
      push(32'(i * 4), 1'b1);
      check("wrap_cnt_le1", 64'(count <= 1), 64'(1));
    end
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Flush with 3 entries held, alongside enq and deq.
    push(32'h40, 1'b0);
    push(32'h44, 1'b0);
    push(32'h48, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h4C, 32'h1234, 1'b1);
    check("flush_count", 64'(count), 64'(0));
    push(32'h100, 1'b0);
    check("post_flush_pc", 64'(deq_pc), 64'(32'h100));
    idle_cycle(1'b1);

    // Mid-operation reset with 2 entries held.
    push(32'h200, 1'b0);
    push(32'h204, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h208, 32'h0, 1'b1);
    check("rst_count", 64'(count), 64'(0));
    check("rst_inst",  64'(deq_inst), 64'(NOP));
    idle_cycle(1'b0);

    // Randomized traffic with unique PCs so stale entries cannot masquerade as live ones.
    pc_seq = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
            1'(($urandom_range(0, 3) != 0)), 32'(pc_seq), $urandom,
            1'(($urandom_range(0, 2) != 0)));
      pc_seq += 4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
